// File: rtl/regfile_access_sequencer_pkg.sv
// Shared types and default sizes for the register-file access sequencer.
package regfile_access_sequencer_pkg;

  localparam int unsigned AW_DEF      = 5;
  localparam int unsigned DW_DEF      = 32;
  localparam int unsigned TIMEOUT_DEF = 16;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_READ     = 3'd1,
    S_ISSUE    = 3'd2,
    S_WAIT_RES = 3'd3,
    S_WRITE    = 3'd4
  } state_e;

endpackage

// File: rtl/regfile_access_sequencer_wait_timer.sv
// Result-wait timer: counts cycles spent waiting for a result and flags the
// last permitted cycle. TIMEOUT = 0 disables expiry entirely.
module regfile_access_sequencer_wait_timer
  import regfile_access_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic expire
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Next count: clear has priority, otherwise advance on each counted cycle.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire = (TIMEOUT != 0) && (count_q == LAST);

endmodule

// File: rtl/regfile_access_sequencer.sv
// Register-file access sequencer: reads two sources, hands operands to the
// execute stage, optionally waits for the result and commits it to the file.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | ready for a new request
// S_READ     | A1/A2 driven, RD1/RD2 captured at end of cycle
// S_ISSUE    | operands offered downstream until accepted
// S_WAIT_RES | waiting for the result, bounded by the wait timer
// S_WRITE    | result written through A3/WD3/WE3
module regfile_access_sequencer
  import regfile_access_sequencer_pkg::*;
#(
  parameter int unsigned AW      = AW_DEF,
  parameter int unsigned DW      = DW_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          REQ_VALID,
  output logic          REQ_READY,
  input  logic [AW-1:0] REQ_SRC1,
  input  logic [AW-1:0] REQ_SRC2,
  input  logic [AW-1:0] REQ_DST,
  input  logic          REQ_WB,
  output logic          OPS_VALID,
  input  logic          OPS_READY,
  output logic [DW-1:0] OPS_A,
  output logic [DW-1:0] OPS_B,
  input  logic          RES_VALID,
  output logic          RES_READY,
  input  logic [DW-1:0] RES_DATA,
  output logic [AW-1:0] A1,
  output logic [AW-1:0] A2,
  output logic [AW-1:0] A3,
  input  logic [DW-1:0] RD1,
  input  logic [DW-1:0] RD2,
  output logic          WE3,
  output logic [DW-1:0] WD3,
  output logic          BUSY,
  output logic          TIMEOUT_ERR
);

  state_e        state_q, state_d;
  logic [AW-1:0] src1_q, src1_d;
  logic [AW-1:0] src2_q, src2_d;
  logic [AW-1:0] dst_q, dst_d;
  logic          wb_q, wb_d;
  logic [DW-1:0] ops_a_q, ops_a_d;
  logic [DW-1:0] ops_b_q, ops_b_d;
  logic [DW-1:0] res_q, res_d;
  logic          timeout_err_q, timeout_err_d;
  logic          timer_clr;
  logic          timer_inc;
  logic          timer_expire;

  regfile_access_sequencer_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk    (CLK),
    .reset  (RESET),
    .clr    (timer_clr),
    .inc    (timer_inc),
    .expire (timer_expire)
  );

  // Next-state, latch updates and per-state outputs.
  always_comb begin
    state_d       = state_q;
    src1_d        = src1_q;
    src2_d        = src2_q;
    dst_d         = dst_q;
    wb_d          = wb_q;
    ops_a_d       = ops_a_q;
    ops_b_d       = ops_b_q;
    res_d         = res_q;
    timeout_err_d = 1'b0;
    REQ_READY     = 1'b0;
    OPS_VALID     = 1'b0;
    RES_READY     = 1'b0;
    A1            = '0;
    A2            = '0;
    A3            = '0;
    WD3           = '0;
    WE3           = 1'b0;
    // Timer runs only inside S_WAIT_RES, so it always enters at zero.
    timer_clr     = (state_q != S_WAIT_RES);
    timer_inc     = (state_q == S_WAIT_RES) && !RES_VALID;

    case (state_q)
      S_IDLE: begin
        REQ_READY = 1'b1;
        if (REQ_VALID) begin
          src1_d  = REQ_SRC1;
          src2_d  = REQ_SRC2;
          dst_d   = REQ_DST;
          wb_d    = REQ_WB;
          state_d = S_READ;
        end
      end
      S_READ: begin
        A1      = src1_q;
        A2      = src2_q;
        ops_a_d = RD1;
        ops_b_d = RD2;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        OPS_VALID = 1'b1;
        if (OPS_READY) begin
          state_d = wb_q ? S_WAIT_RES : S_IDLE;
        end
      end
      S_WAIT_RES: begin
        RES_READY = 1'b1;
        // A result arriving on the last permitted cycle still wins.
        if (RES_VALID) begin
          res_d   = RES_DATA;
          state_d = S_WRITE;
        end else if (timer_expire) begin
          timeout_err_d = 1'b1;
          state_d       = S_IDLE;
        end
      end
      S_WRITE: begin
        A3  = dst_q;
        WD3 = res_q;
        // The register file has no reset, so a reset here must block the commit.
        WE3 = ~RESET;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q       <= S_IDLE;
      src1_q        <= '0;
      src2_q        <= '0;
      dst_q         <= '0;
      wb_q          <= 1'b0;
      ops_a_q       <= '0;
      ops_b_q       <= '0;
      res_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      src1_q        <= src1_d;
      src2_q        <= src2_d;
      dst_q         <= dst_d;
      wb_q          <= wb_d;
      ops_a_q       <= ops_a_d;
      ops_b_q       <= ops_b_d;
      res_q         <= res_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign OPS_A       = ops_a_q;
  assign OPS_B       = ops_b_q;
  assign BUSY        = (state_q != S_IDLE);
  assign TIMEOUT_ERR = timeout_err_q;

endmodule

// File: tb/tb_regfile_access_sequencer.sv
// Directed bench: sequencer paired with an 8-entry register file model.
module tb_regfile_access_sequencer;

  localparam int AW = 5;
  localparam int DW = 32;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          REQ_VALID, REQ_READY;
  logic [AW-1:0] REQ_SRC1, REQ_SRC2, REQ_DST;
  logic          REQ_WB;
  logic          OPS_VALID, OPS_READY;
  logic [DW-1:0] OPS_A, OPS_B;
  logic          RES_VALID, RES_READY;
  logic [DW-1:0] RES_DATA;
  logic [AW-1:0] A1, A2, A3;
  logic [DW-1:0] RD1, RD2;
  logic          WE3;
  logic [DW-1:0] WD3;
  logic          BUSY, TIMEOUT_ERR;

  logic [DW-1:0] rf [8];
  logic          tb_we;
  logic [2:0]    tb_wa;
  logic [DW-1:0] tb_wd;
  int            we_count = 0;
  int            tests_run = 0;
  int            tests_failed = 0;

  always #5 CLK = ~CLK;

  regfile_access_sequencer #(.AW(AW), .DW(DW), .TIMEOUT(4)) dut (
    .CLK(CLK), .RESET(RESET),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_SRC1(REQ_SRC1), .REQ_SRC2(REQ_SRC2), .REQ_DST(REQ_DST), .REQ_WB(REQ_WB),
    .OPS_VALID(OPS_VALID), .OPS_READY(OPS_READY), .OPS_A(OPS_A), .OPS_B(OPS_B),
    .RES_VALID(RES_VALID), .RES_READY(RES_READY), .RES_DATA(RES_DATA),
    .A1(A1), .A2(A2), .A3(A3), .RD1(RD1), .RD2(RD2),
    .WE3(WE3), .WD3(WD3), .BUSY(BUSY), .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  // Register file: combinational reads, write on clock; bench port preloads.
  assign RD1 = rf[A1[2:0]];
  assign RD2 = rf[A2[2:0]];
  always @(posedge CLK) begin
    if (WE3) rf[A3[2:0]] <= WD3;
    else if (tb_we) rf[tb_wa] <= tb_wd;
  end

  // Count every committed write.
  always @(posedge CLK) if (WE3) we_count <= we_count + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic request(input logic [AW-1:0] s1, input logic [AW-1:0] s2,
                         input logic [AW-1:0] d, input logic wb);
    REQ_VALID = 1'b1;
    REQ_SRC1  = s1;
    REQ_SRC2  = s2;
    REQ_DST   = d;
    REQ_WB    = wb;
  endtask

  initial begin
    int we_base;
    for (int i = 0; i < 8; i++) rf[i] = '0;
    RESET = 1'b1; REQ_VALID = 1'b0; REQ_SRC1 = '0; REQ_SRC2 = '0; REQ_DST = '0;
    REQ_WB = 1'b0; OPS_READY = 1'b0; RES_VALID = 1'b0; RES_DATA = '0;
    tb_we = 1'b0; tb_wa = '0; tb_wd = '0;

    // Reset for two cycles.
    tick(); tick();
    RESET = 1'b0;
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_we3", 32'(WE3), 32'd0);
    check("rst_ops_valid", 32'(OPS_VALID), 32'd0);
    check("rst_ops_a", OPS_A, 32'd0);
    check("rst_ops_b", OPS_B, 32'd0);
    check("rst_req_ready", 32'(REQ_READY), 32'd1);
    check("rst_timeout_err", 32'(TIMEOUT_ERR), 32'd0);

    // Preload r1 and r3.
    tb_we = 1'b1; tb_wa = 3'd1; tb_wd = 32'h11; tick();
    tb_wa = 3'd3; tb_wd = 32'h33; tick();
    tb_we = 1'b0;

    // Full write-back transaction with immediate handshakes.
    request(5'd1, 5'd3, 5'd5, 1'b1);
    OPS_READY = 1'b1; RES_VALID = 1'b1; RES_DATA = 32'h44;
    check("wb_c0_req_ready", 32'(REQ_READY), 32'd1);
    tick(); REQ_VALID = 1'b0;
    check("wb_c1_busy", 32'(BUSY), 32'd1);
    check("wb_c1_a1", 32'(A1), 32'd1);
    check("wb_c1_a2", 32'(A2), 32'd3);
    check("wb_c1_res_ready", 32'(RES_READY), 32'd0);
    tick();
    check("wb_c2_ops_valid", 32'(OPS_VALID), 32'd1);
    check("wb_c2_ops_a", OPS_A, 32'h11);
    check("wb_c2_ops_b", OPS_B, 32'h33);
    tick();
    check("wb_c3_res_ready", 32'(RES_READY), 32'd1);
    check("wb_c3_ops_valid", 32'(OPS_VALID), 32'd0);
    tick();
    check("wb_c4_we3", 32'(WE3), 32'd1);
    check("wb_c4_a3", 32'(A3), 32'd5);
    check("wb_c4_wd3", WD3, 32'h44);
    tick();
    check("wb_c5_req_ready", 32'(REQ_READY), 32'd1);
    check("wb_c5_we3", 32'(WE3), 32'd0);
    check("wb_c5_wd3", WD3, 32'd0);

    // Read-only reread of r5 right after the write, with a 3-cycle OPS stall.
    we_base = we_count;
    request(5'd5, 5'd1, 5'd2, 1'b0);
    OPS_READY = 1'b0;
    tick(); REQ_VALID = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("stall%0d_ops_valid", i), 32'(OPS_VALID), 32'd1);
      check($sformatf("stall%0d_ops_a", i), OPS_A, 32'h44);
      check($sformatf("stall%0d_ops_b", i), OPS_B, 32'h11);
      check($sformatf("stall%0d_res_ready", i), 32'(RES_READY), 32'd0);
      tick();
    end
    OPS_READY = 1'b1;
    check("ro_issue_ops_valid", 32'(OPS_VALID), 32'd1);
    tick();
    check("ro_idle_busy", 32'(BUSY), 32'd0);
    check("ro_idle_req_ready", 32'(REQ_READY), 32'd1);
    check("ro_idle_res_ready", 32'(RES_READY), 32'd0);
    check("ro_no_write", 32'(we_count - we_base), 32'd0);

    // Timeout: no result ever arrives.
    RES_VALID = 1'b0;
    we_base = we_count;
    request(5'd1, 5'd3, 5'd6, 1'b1);
    tick(); REQ_VALID = 1'b0;
    tick(); tick();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("to_wait%0d_res_ready", i), 32'(RES_READY), 32'd1);
      check($sformatf("to_wait%0d_err", i), 32'(TIMEOUT_ERR), 32'd0);
      tick();
    end
    check("to_err_pulse", 32'(TIMEOUT_ERR), 32'd1);
    check("to_req_ready", 32'(REQ_READY), 32'd1);
    check("to_busy", 32'(BUSY), 32'd0);
    tick();
    check("to_err_cleared", 32'(TIMEOUT_ERR), 32'd0);
    check("to_no_write", 32'(we_count - we_base), 32'd0);

    // Reset asserted during the WRITE cycle must block the commit.
    we_base = we_count;
    request(5'd1, 5'd3, 5'd5, 1'b1);
    RES_VALID = 1'b1; RES_DATA = 32'h99;
    tick(); REQ_VALID = 1'b0;
    tick(); tick(); tick();
    check("rw_a3", 32'(A3), 32'd5);
    RESET = 1'b1; #1;
    check("rw_we3_suppressed", 32'(WE3), 32'd0);
    tick();
    RESET = 1'b0; RES_VALID = 1'b0;
    check("rw_busy_after_reset", 32'(BUSY), 32'd0);
    check("rw_no_write", 32'(we_count - we_base), 32'd0);
    request(5'd5, 5'd3, 5'd0, 1'b0);
    tick(); REQ_VALID = 1'b0;
    tick();
    check("rw_r5_kept", OPS_A, 32'h44);
    check("rw_r3", OPS_B, 32'h33);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
